// File: rtl/onehot_scan_encoder_pkg.sv
// Shared types and helpers for the one-hot scan encoder.
// The encoder FSM state type and the index-width derivation live here.
package enc_pkg;

    // IDLE: no beats pending, ready for a new vector.
    // BUSY: a beat is presented on the output.
    typedef enum logic {
        ENC_IDLE = 1'b0,
        ENC_BUSY = 1'b1
    } enc_state_t;

    // Index width for an N-bit vector; never less than one bit.
    function automatic int enc_idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/onehot_scan_encoder_lsb_first_finder.sv
// Combinational lowest-set-bit finder.
// Reports the index of the lowest set bit, that bit as a one-hot mask
// (used by the caller to clear it), whether exactly one bit is set,
// and whether any bit is set.  An all-zero mask reports index 0.
module lsb_first_finder
    import enc_pkg::*;
#(
    parameter int N = 4,
    parameter int W = enc_idx_width(N)
) (
    input  logic [N-1:0] i_mask,
    output logic [W-1:0] o_idx,
    output logic [N-1:0] o_lowbit,
    output logic         o_single,
    output logic         o_any
);

    logic [N-1:0] w_lowbit;
    logic [N-1:0] w_rest;

    // Isolate the lowest set bit with the two's-complement trick.
    assign w_lowbit = i_mask & (~i_mask + {{(N-1){1'b0}}, 1'b1});
    assign w_rest   = i_mask & ~w_lowbit;

    // Scan from the top down so the last hit is the lowest set bit.
    always_comb begin
        o_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_mask[i]) begin
                o_idx = W'(i);
            end
        end
    end

    assign o_lowbit = w_lowbit;
    assign o_any    = |i_mask;
    assign o_single = (|i_mask) & ~(|w_rest);

endmodule

// File: rtl/onehot_scan_encoder.sv
// One-hot / request-vector scan encoder.
// Accepts an N-bit vector and emits the binary index of each set bit,
// lowest first, one beat per cycle, with registered outputs.
// Handshake: a transfer happens on a side in any cycle where its valid
// and its ready are both high; the producer holds valid and data stable
// until that cycle, and ready may depend combinationally on the other side.
// Optional feature: define ENC_ZERO_BEAT_EN to add o_zero and emit a
// single index-0 beat for an all-zero vector (otherwise it is dropped).
module onehot_scan_encoder
    import enc_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_vld,
    input  logic [N-1:0]                 i_vec,
    output logic                         o_rdy,
    output logic                         o_vld,
    output logic [enc_idx_width(N)-1:0]  o_idx,
    output logic                         o_last,
`ifdef ENC_ZERO_BEAT_EN
    output logic                         o_zero,
`endif
    input  logic                         i_rdy
);

    localparam int W = enc_idx_width(N);

    // State and registered datapath.  r_mask holds only the bits still
    // to be reported after the beat currently on the output, so the
    // current beat is the last one exactly when r_mask is empty.
    enc_state_t   r_state;
    enc_state_t   w_state_nxt;
    logic [N-1:0] r_mask;
    logic [N-1:0] w_mask_nxt;
    logic         r_vld;
    logic         w_vld_nxt;
    logic [W-1:0] r_idx;
    logic [W-1:0] w_idx_nxt;
    logic         r_last;
    logic         w_last_nxt;
`ifdef ENC_ZERO_BEAT_EN
    logic         r_zero;
    logic         w_zero_nxt;
`endif

    logic         w_rdy;
    logic         w_acc;
    logic         w_hs;
    logic         w_load;
    logic [N-1:0] w_src;
    logic [W-1:0] w_f_idx;
    logic [N-1:0] w_f_lowbit;
    logic         w_f_single;
    logic         w_f_any;

    // Ready only when idle, or when the final beat leaves this cycle.
    assign w_rdy = (r_state == ENC_IDLE) | (r_vld & i_rdy & r_last);
    assign w_acc = i_vld & w_rdy;
    assign w_hs  = r_vld & i_rdy;

    // A new vector is scanned on accept; otherwise the pending bits are.
    assign w_src = w_acc ? i_vec : r_mask;

    // An accepted vector produces beats unless it is zero and the
    // zero-beat feature is off.
`ifdef ENC_ZERO_BEAT_EN
    assign w_load = w_acc;
`else
    assign w_load = w_acc & w_f_any;
`endif

    lsb_first_finder #(
        .N (N),
        .W (W)
    ) u_finder (
        .i_mask   (w_src),
        .o_idx    (w_f_idx),
        .o_lowbit (w_f_lowbit),
        .o_single (w_f_single),
        .o_any    (w_f_any)
    );

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ENC_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: stay busy while beats remain or a new vector loads.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ENC_IDLE: begin
                if (w_load) begin
                    w_state_nxt = ENC_BUSY;
                end
            end
            ENC_BUSY: begin
                if (w_hs && r_last) begin
                    w_state_nxt = w_load ? ENC_BUSY : ENC_IDLE;
                end
            end
            default: w_state_nxt = ENC_IDLE;
        endcase
    end

    // Output/datapath next values: load, advance, retire, or hold.
    always_comb begin
        w_mask_nxt = r_mask;
        w_vld_nxt  = r_vld;
        w_idx_nxt  = r_idx;
        w_last_nxt = r_last;
`ifdef ENC_ZERO_BEAT_EN
        w_zero_nxt = r_zero;
`endif
        if (w_load) begin
            w_vld_nxt  = 1'b1;
            w_idx_nxt  = w_f_idx;
            w_mask_nxt = i_vec & ~w_f_lowbit;
`ifdef ENC_ZERO_BEAT_EN
            w_last_nxt = w_f_single | ~w_f_any;
            w_zero_nxt = ~w_f_any;
`else
            w_last_nxt = w_f_single;
`endif
        end else if (w_hs && r_last) begin
            w_vld_nxt  = 1'b0;
            w_last_nxt = 1'b0;
            w_mask_nxt = '0;
`ifdef ENC_ZERO_BEAT_EN
            w_zero_nxt = 1'b0;
`endif
        end else if (w_hs) begin
            w_idx_nxt  = w_f_idx;
            w_last_nxt = w_f_single;
            w_mask_nxt = r_mask & ~w_f_lowbit;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mask <= '0;
            r_vld  <= 1'b0;
            r_idx  <= '0;
            r_last <= 1'b0;
`ifdef ENC_ZERO_BEAT_EN
            r_zero <= 1'b0;
`endif
        end else begin
            r_mask <= w_mask_nxt;
            r_vld  <= w_vld_nxt;
            r_idx  <= w_idx_nxt;
            r_last <= w_last_nxt;
`ifdef ENC_ZERO_BEAT_EN
            r_zero <= w_zero_nxt;
`endif
        end
    end

    assign o_rdy  = w_rdy;
    assign o_vld  = r_vld;
    assign o_idx  = r_idx;
    assign o_last = r_last;
`ifdef ENC_ZERO_BEAT_EN
    assign o_zero = r_zero;
`endif

endmodule

// File: tb/tb_onehot_scan_encoder.sv
// Bench for onehot_scan_encoder (N=4): directed vectors with hand-computed
// beats pushed into an expected queue; a monitor pops on each output beat.
module tb_onehot_scan_encoder;

  localparam int N  = 4;
  localparam int W  = 2;
  localparam int EW = W + 2;  // {zero, last, idx}

  logic         clk;
  logic         rst_n;
  logic         i_vld;
  logic [N-1:0] i_vec;
  logic         o_rdy;
  logic         o_vld;
  logic [W-1:0] o_idx;
  logic         o_last;
  logic         i_rdy;
  logic         zero_act;
`ifdef ENC_ZERO_BEAT_EN
  logic         o_zero;
  assign zero_act = o_zero;
`else
  assign zero_act = 1'b0;
`endif

  logic [EW-1:0] exp_q[$];
  int            n_tests = 0;
  int            n_fail  = 0;

  onehot_scan_encoder #(.N(N)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_vld   (i_vld),
    .i_vec   (i_vec),
    .o_rdy   (o_rdy),
    .o_vld   (o_vld),
    .o_idx   (o_idx),
    .o_last  (o_last),
`ifdef ENC_ZERO_BEAT_EN
    .o_zero  (o_zero),
`endif
    .i_rdy   (i_rdy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_beat(input logic [W-1:0] idx, input logic last, input logic zero);
    exp_q.push_back({zero, last, idx});
  endtask

  // Advance to just after the n-th next rising edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present a vector (called just after a rising edge) and hold it until
  // accepted; returns just after the accepting edge.
  task automatic send(input logic [N-1:0] v);
    logic ok;
    ok    = 1'b0;
    i_vld = 1'b1;
    i_vec = v;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (o_rdy) begin
        ok = 1'b1;
        break;
      end
    end
    chk("accept", {63'd0, ok}, 64'd1);
    @(posedge clk);
    #1;
    i_vld = 1'b0;
    i_vec = N'($urandom_range(0, 15));
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic [EW-1:0] a;
    if (rst_n && o_vld && i_rdy) begin
      a = {zero_act, o_last, o_idx};
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL beat_unexpected: got zero/last/idx=%b, expected no beat at %0t", a, $time);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          n_fail++;
          $display("FAIL beat: got zero/last/idx=%b expected %b at %0t", a, e, $time);
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    n_fail++;
    $display("FAIL timeout: simulation did not complete");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    i_vld = 1'b0;
    i_vec = '0;
    i_rdy = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_vld",  {63'd0, o_vld},  64'd0);
    chk("rst_idx",  {62'd0, o_idx},  64'd0);
    chk("rst_last", {63'd0, o_last}, 64'd0);
    chk("rst_rdy",  {63'd0, o_rdy},  64'd1);
    step(1);
    rst_n = 1'b1;
    step(1);

    // 1010 at full throughput: idx 1, idx 3 (last); ready on last beat.
    push_beat(2'd1, 1'b0, 1'b0);
    push_beat(2'd3, 1'b1, 1'b0);
    send(4'b1010);
    @(negedge clk); chk("t1_rdy_b0", {63'd0, o_rdy}, 64'd0);
    @(negedge clk); chk("t1_rdy_b1", {63'd0, o_rdy}, 64'd1);
    @(negedge clk); chk("t1_idle",   {63'd0, o_vld}, 64'd0);
    step(1);

    // 0110 under back-pressure: first beat held for 3 cycles.
    i_rdy = 1'b0;
    push_beat(2'd1, 1'b0, 1'b0);
    push_beat(2'd2, 1'b1, 1'b0);
    send(4'b0110);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t2_hold_vld",  {63'd0, o_vld},  64'd1);
      chk("t2_hold_idx",  {62'd0, o_idx},  64'd1);
      chk("t2_hold_last", {63'd0, o_last}, 64'd0);
      chk("t2_hold_rdy",  {63'd0, o_rdy},  64'd0);
    end
    step(1);
    i_rdy = 1'b1;
    step(3);

    // 1000 then 0001 back to back during the last beat: no bubble.
    push_beat(2'd3, 1'b1, 1'b0);
    push_beat(2'd0, 1'b1, 1'b0);
    send(4'b1000);
    send(4'b0001);
    @(negedge clk); chk("t3_no_bubble", {63'd0, o_vld}, 64'd1);
    @(negedge clk); chk("t3_idle",      {63'd0, o_vld}, 64'd0);
    step(1);

    // 1111: four consecutive beats, ready only on the last.
    push_beat(2'd0, 1'b0, 1'b0);
    push_beat(2'd1, 1'b0, 1'b0);
    push_beat(2'd2, 1'b0, 1'b0);
    push_beat(2'd3, 1'b1, 1'b0);
    send(4'b1111);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t4_rdy", {63'd0, o_rdy}, (k == 3) ? 64'd1 : 64'd0);
    end
    step(2);

    // Zero vector.
`ifdef ENC_ZERO_BEAT_EN
    push_beat(2'd0, 1'b1, 1'b1);
    send(4'b0000);
    @(negedge clk); chk("t5_zero_beat", {63'd0, o_vld}, 64'd1);
    @(negedge clk); chk("t5_zero_done", {63'd0, o_vld}, 64'd0);
`else
    send(4'b0000);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("t5_zero_novld", {63'd0, o_vld}, 64'd0);
      chk("t5_zero_rdy",   {63'd0, o_rdy}, 64'd1);
    end
`endif
    step(1);

    // 0101 with reset asserted after the idx=0 beat.
    push_beat(2'd0, 1'b0, 1'b0);
    send(4'b0101);
    step(1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_vld",  {63'd0, o_vld},  64'd0);
    chk("t6_rst_idx",  {62'd0, o_idx},  64'd0);
    chk("t6_rst_last", {63'd0, o_last}, 64'd0);
    chk("t6_rst_rdy",  {63'd0, o_rdy},  64'd1);
    step(2);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t6_post_vld", {63'd0, o_vld}, 64'd0);
      chk("t6_post_rdy", {63'd0, o_rdy}, 64'd1);
    end

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
